// File: rtl/booth_pkg.sv
// booth_pkg: shared constants, state/digit types and window decode
// for the sequential radix-4 Booth multiplier.
package booth_pkg;
  localparam int BITLEN = 17;
  localparam int NDIG   = (BITLEN + 2) / 2;
  localparam int PPW    = BITLEN + 2;
  localparam int ACCW   = 2 * BITLEN + 2;
  localparam int PW     = 2 * BITLEN;
  localparam int CNTW   = $clog2(NDIG);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [2:0] {ZERO, P1, P2, M2, M1} digit_t;

  function automatic digit_t booth_digit(input logic [2:0] w);
    digit_t d;
    unique case (w)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/booth_mul_seq_pp.sv
// booth_digit_pp: one radix-4 Booth partial product,
// sign-extended to BITLEN+2 bits.
module booth_digit_pp
  import booth_pkg::*;
(
  input  logic [2:0]        w,
  input  logic [BITLEN-1:0] a,
  output logic [PPW-1:0]    pp
);
  logic [PPW-1:0] a1;
  logic [PPW-1:0] a2;

  assign a1 = {2'b00, a};
  assign a2 = {1'b0, a, 1'b0};

  always_comb begin
    pp = '0;
    unique case (booth_digit(w))
      P1:      pp = a1;
      P2:      pp = a2;
      M1:      pp = -a1;
      M2:      pp = -a2;
      default: pp = '0;
    endcase
  end
endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative unsigned multiplier retiring one
// radix-4 Booth digit per cycle through a single pp selector.
module booth_mul_seq
  import booth_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BITLEN-1:0] in_a,
  input  logic [BITLEN-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PW-1:0]     out_p,
  output logic              busy
);
  state_t            state;
  state_t            nstate;
  logic [BITLEN-1:0] mcand;
  logic [PPW-1:0]    rec;
  logic [ACCW-1:0]   acc;
  logic [ACCW-1:0]   acc_nxt;
  logic [ACCW-1:0]   term;
  logic [CNTW-1:0]   cnt;
  logic [PW-1:0]     prod;
  logic [2:0]        win;
  logic [PPW-1:0]    pp;
  logic              accept;
  logic              last;

  assign accept = in_valid & in_ready;
  assign last   = (cnt == CNTW'(NDIG - 1));
  assign win    = rec[{cnt, 1'b0} +: 3];

  booth_digit_pp u_pp (
    .w  (win),
    .a  (mcand),
    .pp (pp)
  );

  // weight the digit by 4^cnt; wraps modulo the accumulator width
  assign term    = {{(ACCW-PPW){pp[PPW-1]}}, pp} << {cnt, 1'b0};
  assign acc_nxt = acc + term;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (accept) nstate = BUSY;
      BUSY:    if (last) nstate = DONE;
      DONE:    if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == BUSY) || (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mcand <= '0;
      rec   <= '0;
      acc   <= '0;
      cnt   <= '0;
      prod  <= '0;
    end else if (accept) begin
      mcand <= in_a;
      rec   <= {1'b0, in_b, 1'b0};
      acc   <= '0;
      cnt   <= '0;
    end else if (state == BUSY) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (last) prod <= acc_nxt[PW-1:0];
    end
  end

  assign out_p = prod;
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed + random products checked through
// a scoreboard queue drained by an output monitor.
module tb_booth_mul_seq;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] in_a = '0;
  logic [16:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [33:0] out_p;
  logic        busy;

  int          nchk = 0;
  int          nfail = 0;
  bit          rnd = 1'b0;
  logic [33:0] q[$];

  booth_mul_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // monitor: one pop per completed output handshake
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 64'(out_p), 64'hDEAD);
      end else begin
        chk("product", 64'(out_p), 64'(q.pop_front()));
      end
    end
  end

  task automatic issue(input logic [16:0] a, input logic [16:0] b,
                       input logic [33:0] exp, input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      if (rnd) out_ready = 1'($urandom % 2);
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      return;
    end
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    if (push) q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = 17'($urandom);
    in_b = 17'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic lat(input logic [16:0] a, input logic [16:0] b,
                     input logic [33:0] exp);
    out_ready = 1'b0;
    issue(a, b, exp, 1'b1);
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      chk("latency_valid", 64'(out_valid), 64'(k == 9));
      chk("ready_low", 64'(in_ready), 64'd0);
      chk("busy_high", 64'(busy), 64'd1);
    end
    drain();
  endtask

  initial begin
    logic [16:0] ra;
    logic [16:0] rb;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_p", 64'(out_p), 64'd0);
    reset_n = 1'b1;

    lat(17'd3, 17'd5, 34'h0_0000_000F);

    out_ready = 1'b1;
    issue(17'd7, 17'd6, 34'h0_0000_002A, 1'b1);
    drain();
    issue(17'h1FFFF, 17'h1FFFF, 34'h3_FFFC_0001, 1'b1);
    issue(17'h00000, 17'h1FFFF, 34'h0_0000_0000, 1'b1);
    issue(17'h1FFFF, 17'h00001, 34'h0_0001_FFFF, 1'b1);
    issue(17'h00001, 17'h1FFFF, 34'h0_0001_FFFF, 1'b1);
    issue(17'h10000, 17'h10000, 34'h1_0000_0000, 1'b1);
    drain();

    // hold DONE with out_ready low while junk in_valid is offered
    out_ready = 1'b0;
    issue(17'h10000, 17'd2, 34'h0_0002_0000, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reach_done", 64'(out_valid), 64'd1);
    in_a = 17'd5;
    in_b = 17'd5;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_p", 64'(out_p), 64'h2_0000);
      chk("hold_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_ready", 64'(in_ready), 64'd1);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("hold_popped", 64'(q.size()), 64'd0);

    // abort mid-operation at cnt=4
    issue(17'h1234, 17'h0567, 34'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_ready", 64'(in_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_p", 64'(out_p), 64'd0);
    lat(17'd2, 17'd2, 34'd4);

    rnd = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        out_ready = 1'($urandom % 2);
      end
      ra = 17'($urandom);
      rb = 17'($urandom);
      issue(ra, rb, {17'd0, ra} * {17'd0, rb}, 1'b1);
    end
    rnd = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end
endmodule
